program_launcher: RTL

//   Front-end conditioner between the board push-buttons and the processor top level.
//   - Synchronises and debounces the launch buttons and the CPU reset button.
//   - Turns each clean press into a program_selector code, held for a fixed number of cycles.
//     The hold is long enough for regfile to copy switch input and the program's start state.
//   - Replaces the raw-button if/else selector logic and the disabled debounce instances.

---
 rtl/program_launcher.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/program_launcher.sv
// program_launcher: conditions the board push-buttons for the processor.
// Raw buttons are synchronised and debounced; each clean launch press becomes
// a program_selector code held for HOLD_CYCLES cycles, and the debounced
// reset button drives cpu_reset. The FSM state is kept in the signal 'state'.
module program_launcher #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 4,
    parameter int SEL_WIDTH       = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 btn_reset,
    input  logic [4:0]           btn_launch,
    output logic                 cpu_reset,
    output logic [SEL_WIDTH-1:0] program_selector,
    output logic                 busy
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Bit 5 is the reset button, bits 4:0 are the launch buttons.
    logic [5:0]       raw;
    logic [5:0]       s1;
    logic [5:0]       s2;
    logic [5:0]       db;
    logic [5:0]       db_prev;
    logic [CNT_W-1:0] cnt [6];
    logic [4:0]       press;
    logic [2:0]       press_code;
    logic [2:0]       sel;
    logic [HOLD_W-1:0] hold_cnt;
    state_t           state;

    assign raw = {btn_reset, btn_launch};

    // Two-flop synchroniser for every button input.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            db <= '0;
            for (int i = 0; i < 6; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Previous debounced levels for edge detection, and the registered cpu reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            db_prev   <= '0;
            cpu_reset <= 1'b0;
        end else begin
            db_prev   <= db;
            cpu_reset <= db[5];
        end
    end

    assign press = db[4:0] & ~db_prev[4:0];

    // Priority encode the press events: fib (bit 0) wins over everything else.
    always_comb begin
        press_code = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (press[i]) press_code = 3'(i + 1);
        end
    end

    // Launch FSM with registered selector and busy outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            sel      <= 3'd0;
            hold_cnt <= '0;
            busy     <= 1'b0;
        end else if (cpu_reset) begin
            // Synchronous abort: nothing launches while the processor is held in reset.
            state    <= IDLE;
            sel      <= 3'd0;
            hold_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (press != 5'd0) begin
                        sel      <= press_code;
                        hold_cnt <= HOLD_LOAD;
                        busy     <= 1'b1;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    // Presses arriving here are dropped on purpose.
                    if (hold_cnt == HOLD_W'(1)) begin
                        sel   <= 3'd0;
                        state <= RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    // Wait for every launch button to be let go so a held button cannot relaunch.
                    if (db[4:0] == 5'd0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    sel   <= 3'd0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign program_selector = SEL_WIDTH'(sel);

endmodule
